// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the hex entry decoder.
package hex_entry_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        DECODE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int WORD_W  = 16;
    // Largest magnitude representable with the default 10-bit magnitude output.
    localparam int MAX_MAG = 1023;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: 2-FF synchroniser, debounce counter and a
// one-cycle pulse on each accepted press (debounced 1->0 transition).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;

    // Bring the asynchronous key level into the clk domain; idles released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing
    // samples; a sample matching the current level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b1;
            count <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                count <= '0;
                // Old level high means the new level is low: a press.
                press <= level;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_entry_decoder.sv
// Nibble-by-nibble entry of a 16-bit two's-complement word from SW[3:0] and
// an enter key, followed by decode to sign + magnitude with overflow flag.
module hex_entry_decoder
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_DIGITS      = 4,
    parameter int MAG_WIDTH       = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           digit_in,
    input  logic                 key_enter_n,
    input  logic                 key_clear_n,
    output logic [WORD_W-1:0]    value,
    output logic [2:0]           digit_count,
    output logic [MAG_WIDTH-1:0] magnitude,
    output logic                 negative,
    output logic                 overflow,
    output logic                 valid
);

    // Overflow threshold derived from the magnitude width (MAX_MAG at default).
    localparam logic [WORD_W-1:0] MAG_LIMIT = WORD_W'((1 << MAG_WIDTH) - 1);

    logic enter_p;
    logic clear_p;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_enter_n),
        .press (enter_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_clear_n),
        .press (clear_p)
    );

    state_t                 state, state_n;
    logic [WORD_W-1:0]      value_n;
    logic [2:0]             count_n;
    logic [MAG_WIDTH-1:0]   mag_n;
    logic                   neg_n;
    logic                   ovf_n;
    logic                   valid_n;
    logic [WORD_W-1:0]      abs_val;
    logic [2:0]             count_inc;

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            value       <= '0;
            digit_count <= '0;
            magnitude   <= '0;
            negative    <= 1'b0;
            overflow    <= 1'b0;
            valid       <= 1'b0;
        end else begin
            state       <= state_n;
            value       <= value_n;
            digit_count <= count_n;
            magnitude   <= mag_n;
            negative    <= neg_n;
            overflow    <= ovf_n;
            valid       <= valid_n;
        end
    end

    // Next-state and datapath; clear takes priority over everything.
    always_comb begin
        state_n   = state;
        value_n   = value;
        count_n   = digit_count;
        mag_n     = magnitude;
        neg_n     = negative;
        ovf_n     = overflow;
        valid_n   = valid;
        count_inc = digit_count + 3'd1;
        // 0x8000 negates to itself, which still lands above the limit.
        abs_val   = value[WORD_W-1] ? (~value + 1'b1) : value;

        if (clear_p) begin
            state_n = IDLE;
            value_n = '0;
            count_n = '0;
            mag_n   = '0;
            neg_n   = 1'b0;
            ovf_n   = 1'b0;
            valid_n = 1'b0;
        end else begin
            case (state)
                IDLE, ENTRY: begin
                    if (enter_p) begin
                        value_n = {value[WORD_W-5:0], digit_in};
                        count_n = count_inc;
                        state_n = (count_inc == 3'(NUM_DIGITS)) ? DECODE : ENTRY;
                    end
                end
                DECODE: begin
                    // Enter pulses landing here are dropped.
                    neg_n   = value[WORD_W-1];
                    ovf_n   = (abs_val > MAG_LIMIT);
                    mag_n   = (abs_val > MAG_LIMIT) ? '0 : abs_val[MAG_WIDTH-1:0];
                    valid_n = 1'b1;
                    state_n = DONE;
                end
                DONE: begin
                    if (enter_p) begin
                        value_n = {{(WORD_W-4){1'b0}}, digit_in};
                        count_n = 3'd1;
                        mag_n   = '0;
                        neg_n   = 1'b0;
                        ovf_n   = 1'b0;
                        valid_n = 1'b0;
                        state_n = ENTRY;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: doc/hex_entry_decoder.md
Name: hex_entry_decoder

Overview:
Digit-by-digit hex entry block for the DE-series board. It is the inverse of the switch-to-hex display path. The operator keys in a 16-bit two's-complement word one nibble at a time using SW[3:0] and a push-button. The block then decodes the word back to sign plus 10-bit magnitude, with an overflow flag. It sits between the raw board inputs (SW, KEY) and the existing LEDR/HEX display logic.

Parameters:
DEBOUNCE_CYCLES, 500000, clk cycles a key level must be stable before it is accepted (10 ms at 50 MHz; benches use 4).
NUM_DIGITS, 4, nibbles per entered word.
MAG_WIDTH, 10, width of the decoded magnitude.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
digit_in  in  4  nibble to enter (SW[3:0]); sampled on the accepted enter press
key_enter_n  in  1  enter push-button, active-low, asynchronous to clk
key_clear_n  in  1  clear push-button, active-low, asynchronous to clk
value  out  16  entered word, shifted left one nibble per press, newest nibble in [3:0]
digit_count  out  3  nibbles entered so far (0..NUM_DIGITS)
magnitude  out  MAG_WIDTH  absolute value of the signed word; 0 on overflow
negative  out  1  value[15] at decode time
overflow  out  1  |value| > 2^MAG_WIDTH-1
valid  out  1  magnitude, negative and overflow are current

Behaviour:
- Reset (async, active-high): every output is 0 and the FSM is in IDLE. Synchronisers and debounce state go to the "released" level (1).
- Each key passes through a 2-FF synchroniser and then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronised samples.
  - Any mismatch restarts the count.
- A debounced 1->0 transition (a press) produces a 1-cycle pulse: enter_p or clear_p. Releases produce no pulse.
- FSM states: IDLE, ENTRY, DECODE, DONE.
  - IDLE or ENTRY, on enter_p: value <= {value[11:0], digit_in}; digit_count++.
    - Next state is DECODE if the new count equals NUM_DIGITS.
    - Otherwise next state is ENTRY.
  - DECODE (1 cycle): register the results and go to DONE.
    - negative = value[15].
    - abs = negative ? (~value + 1) : value, computed at 16 bits.
    - overflow = (abs > 1023). This includes 0x8000, whose abs stays 0x8000.
    - magnitude = overflow ? 0 : abs[9:0].
    - valid <= 1.
  - DONE: valid stays 1 and the outputs hold.
    - On enter_p: value <= {12'h000, digit_in}; digit_count <= 1; valid, magnitude, negative and overflow <= 0; go to ENTRY.
- Latency: valid rises exactly 2 clk edges after the clk edge at which the final enter_p is high.
- clear_p in any state: value, digit_count, magnitude, negative, overflow and valid go to 0; go to IDLE.
- clear_p and enter_p in the same cycle: clear wins and the digit is discarded.
- Pulses arriving during DECODE:
  - enter_p is ignored (digit lost).
  - clear_p is honoured.
- digit_count never exceeds NUM_DIGITS.
- Reset asserted mid-entry or mid-debounce: immediate return to the reset state. A key held through reset deassertion is accepted only after a full debounce interval.

Decomposition:
- Package hex_entry_pkg holds:
  - the FSM state enum (IDLE, ENTRY, DECODE, DONE);
  - the constants WORD_W=16 and MAX_MAG=1023.
- Sub-module key_debounce (params DEBOUNCE_CYCLES): contains the synchroniser, counter and press-pulse output. It is instantiated twice, once per key.

Test Plan:
- Press enter with digit_in 0,0,0,A (DEBOUNCE_CYCLES=4) -> value=0x000A, negative=0, magnitude=10, overflow=0, valid=1 two edges after the 4th pulse.
- Enter F,F,F,F -> negative=1, magnitude=1. Enter F,F,F,6 -> negative=1, magnitude=10.
- Boundaries:
  - 0x03FF -> magnitude=1023, overflow=0.
  - 0x0400 -> overflow=1, magnitude=0.
  - 0xFC01 -> negative=1, magnitude=1023.
  - 0xFC00 -> overflow=1.
  - 0x8000 -> overflow=1, negative=1.
- Bounce rejection: key_enter_n low for 2 cycles then high, repeated 5 times -> digit_count stays 0. Then a press held for 10 cycles -> exactly one digit accepted.
- Clear handling:
  - Clear after 2 digits -> value=0, digit_count=0, valid=0.
  - Clear and enter pulses forced in the same cycle -> IDLE, digit_count=0.
  - Enter pressed in DONE with digit 7 -> value=0x0007, digit_count=1, valid=0.
- Assert rst for 1 cycle after 3 digits -> all outputs 0 asynchronously. Next four presses 1,2,3,4 -> value=0x1234, magnitude=0, overflow=1.
